flash_burst_ctrl: RTL

Parametrised SPI NOR flash read engine (SPI mode 0), successor to the single-byte flash controller. Accepts one request of address, length and mode, then streams 1..2^LEN_NBIT bytes back, one rdv pulse per byte, under a single chip-select window. Also supports a JEDEC-ID read mode. Sits between the waveform loader and the board flash pins.

---
 rtl/flash_burst_ctrl_if.sv | 39 +++
 rtl/flash_burst_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/flash_burst_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : flash_burst_ctrl_if                                       |
// | Description: Request/response and flash pin bundle for the SPI NOR     |
// |              burst read engine. 'master' is the requester/flash side,  |
// |              'slave' is the engine itself.                             |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
interface flash_burst_ctrl_if #(
  parameter int ADDR_NBIT = 24,
  parameter int DATA_NBIT = 8,
  parameter int LEN_NBIT  = 8
);
  logic                 rd;
  logic [ADDR_NBIT-1:0] raddr;
  logic [LEN_NBIT-1:0]  rlen;
  logic                 rmode;
  logic                 busy;
  logic [DATA_NBIT-1:0] rdata;
  logic                 rdv;
  logic                 rdone;
  logic                 sclk;
  logic                 cs_n;
  logic                 sdi;
  logic                 sdo;
  logic                 wp;
  logic                 hold;

  modport master (
    output rd, raddr, rlen, rmode, sdi,
    input  busy, rdata, rdv, rdone, sclk, cs_n, sdo, wp, hold
  );

  modport slave (
    input  rd, raddr, rlen, rmode, sdi,
    output busy, rdata, rdv, rdone, sclk, cs_n, sdo, wp, hold
  );
endinterface
`default_nettype wire

// File: rtl/flash_burst_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : flash_burst_ctrl                                          |
// | Description: SPI NOR (mode 0) burst read engine. One request streams   |
// |              rlen+1 words under a single cs_n window; rmode=1 reads    |
// |              the JEDEC ID (0x9F, no address phase).                    |
// |              Optional macro FLASH_FAST_READ_EN: opcode 0x0B plus 8     |
// |              dummy sclk periods between address and data.              |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module flash_burst_ctrl #(
  parameter int SCLK_DIV  = 4,
  parameter int ADDR_NBIT = 24,
  parameter int DATA_NBIT = 8,
  parameter int LEN_NBIT  = 8
) (
  input  logic              i_mclk,
  input  logic              i_rst,
  flash_burst_ctrl_if.slave fbus
);

`ifdef FLASH_FAST_READ_EN
  typedef enum logic [2:0] {S_IDLE, S_INS, S_ADDR, S_DUMMY, S_DATA, S_GAP} state_t;
  localparam logic [7:0] c_op_read = 8'h0B;
`else
  typedef enum logic [2:0] {S_IDLE, S_INS, S_ADDR, S_DATA, S_GAP} state_t;
  localparam logic [7:0] c_op_read = 8'h03;
`endif
  localparam logic [7:0] c_op_jedec = 8'h9F;

  localparam int c_cnt_w  = $clog2(SCLK_DIV);
  localparam int c_bmax0  = (ADDR_NBIT > DATA_NBIT) ? ADDR_NBIT : DATA_NBIT;
  localparam int c_bmax   = (c_bmax0 > 8) ? c_bmax0 : 8;
  localparam int c_bcnt_w = $clog2(c_bmax + 1);
  localparam int c_tx_w   = 8 + ADDR_NBIT;

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SCLK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(SCLK_DIV / 2);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_sclk_cnt;
  logic [c_bcnt_w-1:0]  r_bcnt;
  logic [c_tx_w-1:0]    r_tx;
  logic [DATA_NBIT-2:0] r_rx;
  logic [LEN_NBIT-1:0]  r_wcnt;
  logic [LEN_NBIT-1:0]  r_len;
  logic                 r_mode;
  logic [DATA_NBIT-1:0] r_rdata;

  logic                 w_accept;
  logic                 w_tick;
  logic                 w_active;
  logic                 w_last_bit;
  logic                 w_rdv;
  logic                 w_rdone;
  logic [DATA_NBIT-1:0] w_word;

  assign w_accept = fbus.rd && (r_state == S_IDLE);
  assign w_tick   = (r_sclk_cnt == c_cnt_last);
`ifdef FLASH_FAST_READ_EN
  assign w_active = (r_state == S_INS) || (r_state == S_ADDR) ||
                    (r_state == S_DUMMY) || (r_state == S_DATA);
`else
  assign w_active = (r_state == S_INS) || (r_state == S_ADDR) || (r_state == S_DATA);
`endif

  // The final bit of a word is taken straight from sdi so the word is
  // presented in the very tick cycle that samples it.
  assign w_word  = {r_rx, fbus.sdi};
  assign w_rdv   = (r_state == S_DATA) && w_tick && w_last_bit;
  assign w_rdone = w_rdv && (r_wcnt == r_len);

  // The tx shifter holds opcode+address left-aligned and shifts in zeros,
  // so sdo is naturally 0 in the dummy and data phases.
  assign fbus.sdo   = r_tx[c_tx_w-1];
  assign fbus.sclk  = w_active && (r_sclk_cnt >= c_cnt_half);
  assign fbus.cs_n  = ~w_active;
  assign fbus.busy  = (r_state != S_IDLE);
  assign fbus.rdv   = w_rdv;
  assign fbus.rdone = w_rdone;
  assign fbus.rdata = w_rdv ? w_word : r_rdata;
  assign fbus.wp    = 1'b1;
  assign fbus.hold  = 1'b1;

  // State register.
  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and end-of-phase detection.
  always_comb begin
    w_state_nxt = r_state;
    w_last_bit  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_INS;
      end
      S_INS: begin
        w_last_bit = (r_bcnt == c_bcnt_w'(7));
        if (w_tick && w_last_bit) w_state_nxt = r_mode ? S_DATA : S_ADDR;
      end
      S_ADDR: begin
        w_last_bit = (r_bcnt == c_bcnt_w'(ADDR_NBIT - 1));
`ifdef FLASH_FAST_READ_EN
        if (w_tick && w_last_bit) w_state_nxt = S_DUMMY;
`else
        if (w_tick && w_last_bit) w_state_nxt = S_DATA;
`endif
      end
`ifdef FLASH_FAST_READ_EN
      S_DUMMY: begin
        w_last_bit = (r_bcnt == c_bcnt_w'(7));
        if (w_tick && w_last_bit) w_state_nxt = S_DATA;
      end
`endif
      S_DATA: begin
        w_last_bit = (r_bcnt == c_bcnt_w'(DATA_NBIT - 1));
        if (w_rdone) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (w_tick) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // sclk divider (parked in IDLE) and per-phase bit counter.
  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) begin
      r_sclk_cnt <= '0;
      r_bcnt     <= '0;
    end else begin
      if (r_state == S_IDLE || w_tick) r_sclk_cnt <= '0;
      else                             r_sclk_cnt <= r_sclk_cnt + c_cnt_w'(1);
      if (!w_active)                   r_bcnt <= '0;
      else if (w_tick)                 r_bcnt <= w_last_bit ? '0 : r_bcnt + c_bcnt_w'(1);
    end
  end

  // Request capture, tx/rx shifters, word counter and held read data.
  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) begin
      r_tx    <= '0;
      r_rx    <= '0;
      r_wcnt  <= '0;
      r_len   <= '0;
      r_mode  <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_tx   <= fbus.rmode ? {c_op_jedec, {ADDR_NBIT{1'b0}}} : {c_op_read, fbus.raddr};
        r_len  <= fbus.rlen;
        r_mode <= fbus.rmode;
        r_wcnt <= '0;
      end else begin
        if (w_tick && w_active)          r_tx   <= {r_tx[c_tx_w-2:0], 1'b0};
        if (w_tick && r_state == S_DATA) r_rx   <= w_word[DATA_NBIT-2:0];
        if (w_rdv)                       r_wcnt <= r_wcnt + LEN_NBIT'(1);
      end
      if (w_rdv) r_rdata <= w_word;
    end
  end

endmodule
`default_nettype wire
